// File: rtl/de2_70_ethernet_st_tx_arbiter.sv
// Two-sink Avalon-ST packet arbiter with round-robin grant on SOP, stray-beat draining in idle
// and saturating packet/drop statistics.
module de2_70_ethernet_st_tx_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned EMPTY_W = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_error,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,

  input  logic               in1_valid,
  output logic               in1_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_error,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_error,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_channel,

  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;

  logic sop0, sop1, done0, done1, stray0, stray1;

  assign sop0   = in0_valid & in0_startofpacket;
  assign sop1   = in1_valid & in1_startofpacket;
  assign done0  = (state_q == StGrant0) & in0_valid & out_ready & in0_endofpacket;
  assign done1  = (state_q == StGrant1) & in1_valid & out_ready & in1_endofpacket;
  assign stray0 = (state_q == StIdle) & in0_valid & ~in0_startofpacket;
  assign stray1 = (state_q == StIdle) & in1_valid & ~in1_startofpacket;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle: begin
        // On a tie the sink that did not win last time is served.
        if (sop0 && sop1) state_d = last_grant_q ? StGrant0 : StGrant1;
        else if (sop0)    state_d = StGrant0;
        else if (sop1)    state_d = StGrant1;
      end
      StGrant0: if (done0) begin
        state_d      = StIdle;
        last_grant_d = 1'b0;
      end
      StGrant1: if (done1) begin
        state_d      = StIdle;
        last_grant_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid         = 1'b0;
    out_data          = '0;
    out_error         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = '0;
    out_channel       = last_grant_q;
    in0_ready         = 1'b0;
    in1_ready         = 1'b0;
    busy              = 1'b0;
    case (state_q)
      StIdle: begin
        in0_ready = stray0 & ~reset;
        in1_ready = stray1 & ~reset;
      end
      StGrant0: begin
        out_valid         = in0_valid & ~reset;
        out_data          = in0_data;
        out_error         = in0_error;
        out_startofpacket = in0_startofpacket;
        out_endofpacket   = in0_endofpacket;
        out_empty         = in0_empty;
        out_channel       = 1'b0;
        in0_ready         = out_ready & ~reset;
        busy              = 1'b1;
      end
      StGrant1: begin
        out_valid         = in1_valid & ~reset;
        out_data          = in1_data;
        out_error         = in1_error;
        out_startofpacket = in1_startofpacket;
        out_endofpacket   = in1_endofpacket;
        out_empty         = in1_empty;
        out_channel       = 1'b1;
        in1_ready         = out_ready & ~reset;
        busy              = 1'b1;
      end
      default: ;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      drop_cnt <= '0;
    end else begin
      pkt_cnt0 <= sat_add(pkt_cnt0, {1'b0, done0});
      pkt_cnt1 <= sat_add(pkt_cnt1, {1'b0, done1});
      drop_cnt <= sat_add(drop_cnt, {1'b0, stray0} + {1'b0, stray1});
    end
  end

endmodule

// File: tb/tb_de2_70_ethernet_st_tx_arbiter.sv
// Randomized and directed bench for the two-sink packet arbiter, checked every cycle against a
// packet-ownership model; a second instance with 2-bit counters exercises saturation.
module tb_de2_70_ethernet_st_tx_arbiter;

  logic clk, reset;
  logic in0_valid, in0_ready, in0_error, in0_startofpacket, in0_endofpacket;
  logic [31:0] in0_data;
  logic [1:0]  in0_empty;
  logic in1_valid, in1_ready, in1_error, in1_startofpacket, in1_endofpacket;
  logic [31:0] in1_data;
  logic [1:0]  in1_empty;
  logic out_valid, out_ready, out_error, out_startofpacket, out_endofpacket, out_channel, busy;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic [15:0] pkt_cnt0, pkt_cnt1, drop_cnt;

  logic s_in0_ready, s_in1_ready, s_out_valid, s_out_error, s_out_sop, s_out_eop;
  logic s_out_channel, s_busy;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_empty, s_pkt_cnt0, s_pkt_cnt1, s_drop_cnt;

  de2_70_ethernet_st_tx_arbiter dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_error(in0_error),
    .in0_startofpacket(in0_startofpacket), .in0_endofpacket(in0_endofpacket),
    .in0_empty(in0_empty),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_error(in1_error),
    .in1_startofpacket(in1_startofpacket), .in1_endofpacket(in1_endofpacket),
    .in1_empty(in1_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_error(out_error),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_empty(out_empty), .out_channel(out_channel),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt), .busy(busy)
  );

  de2_70_ethernet_st_tx_arbiter #(.DATA_W(32), .EMPTY_W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(s_in0_ready), .in0_data(in0_data), .in0_error(in0_error),
    .in0_startofpacket(in0_startofpacket), .in0_endofpacket(in0_endofpacket),
    .in0_empty(in0_empty),
    .in1_valid(in1_valid), .in1_ready(s_in1_ready), .in1_data(in1_data), .in1_error(in1_error),
    .in1_startofpacket(in1_startofpacket), .in1_endofpacket(in1_endofpacket),
    .in1_empty(in1_empty),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_error(s_out_error), .out_startofpacket(s_out_sop), .out_endofpacket(s_out_eop),
    .out_empty(s_out_empty), .out_channel(s_out_channel),
    .pkt_cnt0(s_pkt_cnt0), .pkt_cnt1(s_pkt_cnt1), .drop_cnt(s_drop_cnt), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: who owns the output (-1 = nobody), who won last, and plain event counts.
  int     m_owner;
  int     m_last;
  longint m_pkt0, m_pkt1, m_drop;
  bit     m_live = 0;

  always @(negedge clk) begin
    logic       e_valid, e_r0, e_r1, e_ch, e_busy;
    logic [31:0] e_data;
    logic       e_err, e_sop, e_eop;
    logic [1:0] e_empty;
    if (reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in0_ready", in0_ready, 0);
      chk("rst_in1_ready", in1_ready, 0);
      m_owner = -1; m_last = 1; m_pkt0 = 0; m_pkt1 = 0; m_drop = 0; m_live = 1;
    end else if (m_live) begin
      e_data = '0; e_err = 0; e_sop = 0; e_eop = 0; e_empty = '0;
      if (m_owner < 0) begin
        e_valid = 0; e_ch = m_last[0]; e_busy = 0;
        e_r0 = in0_valid && !in0_startofpacket;
        e_r1 = in1_valid && !in1_startofpacket;
      end else if (m_owner == 0) begin
        e_valid = in0_valid; e_ch = 0; e_busy = 1; e_r0 = out_ready; e_r1 = 0;
        e_data = in0_data; e_err = in0_error; e_sop = in0_startofpacket;
        e_eop = in0_endofpacket; e_empty = in0_empty;
      end else begin
        e_valid = in1_valid; e_ch = 1; e_busy = 1; e_r0 = 0; e_r1 = out_ready;
        e_data = in1_data; e_err = in1_error; e_sop = in1_startofpacket;
        e_eop = in1_endofpacket; e_empty = in1_empty;
      end
      chk("out_valid", out_valid, e_valid);
      chk("in0_ready", in0_ready, e_r0);
      chk("in1_ready", in1_ready, e_r1);
      chk("out_channel", out_channel, e_ch);
      chk("busy", busy, e_busy);
      chk("pkt_cnt0", pkt_cnt0, sat(m_pkt0, 16));
      chk("pkt_cnt1", pkt_cnt1, sat(m_pkt1, 16));
      chk("drop_cnt", drop_cnt, sat(m_drop, 16));
      chk("sat_pkt_cnt0", s_pkt_cnt0, sat(m_pkt0, 2));
      chk("sat_pkt_cnt1", s_pkt_cnt1, sat(m_pkt1, 2));
      chk("sat_drop_cnt", s_drop_cnt, sat(m_drop, 2));
      if (e_valid) begin
        chk("out_data", out_data, e_data);
        chk("out_error", out_error, e_err);
        chk("out_sop", out_startofpacket, e_sop);
        chk("out_eop", out_endofpacket, e_eop);
        chk("out_empty", out_empty, e_empty);
      end
      if (m_owner < 0) begin
        m_drop += e_r0 + e_r1;
        if ((in0_valid && in0_startofpacket) && (in1_valid && in1_startofpacket))
          m_owner = 1 - m_last;
        else if (in0_valid && in0_startofpacket) m_owner = 0;
        else if (in1_valid && in1_startofpacket) m_owner = 1;
      end else if (e_valid && out_ready && e_eop) begin
        if (m_owner == 0) m_pkt0++; else m_pkt1++;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        err, sop, eop;
    logic [1:0]  empty;
  } beat_t;

  typedef struct {
    int          cyc;
    logic        ch;
    logic [31:0] data;
    logic        eop;
  } xfer_t;

  beat_t q0[$], q1[$];
  xfer_t xlog[$];
  int    cyc;

  task automatic add_beat(input int which, input logic [31:0] d, input logic sop,
                          input logic eop);
    beat_t b;
    b.data = d; b.sop = sop; b.eop = eop;
    b.err = 1'($urandom); b.empty = 2'($urandom);
    if (which == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic add_pkt(input int which, input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) add_beat(which, base + i, i == 0, i == len - 1);
  endtask

  // pr < 0 toggles out_ready, high on odd cycles; prst is a per-mille reset chance per cycle.
  task automatic run_cycles(input int n, input int p0, input int p1, input int pr,
                            input int prst);
    bit f0, f1;
    for (int k = 0; k < n; k++) begin
      if (q0.size() > 0 && $urandom_range(99) < p0) begin
        in0_valid = 1; in0_data = q0[0].data; in0_error = q0[0].err;
        in0_startofpacket = q0[0].sop; in0_endofpacket = q0[0].eop; in0_empty = q0[0].empty;
      end else begin
        in0_valid = 0; in0_data = $urandom; in0_error = 1'($urandom);
        in0_startofpacket = 1'($urandom); in0_endofpacket = 1'($urandom);
        in0_empty = 2'($urandom);
      end
      if (q1.size() > 0 && $urandom_range(99) < p1) begin
        in1_valid = 1; in1_data = q1[0].data; in1_error = q1[0].err;
        in1_startofpacket = q1[0].sop; in1_endofpacket = q1[0].eop; in1_empty = q1[0].empty;
      end else begin
        in1_valid = 0; in1_data = $urandom; in1_error = 1'($urandom);
        in1_startofpacket = 1'($urandom); in1_endofpacket = 1'($urandom);
        in1_empty = 2'($urandom);
      end
      out_ready = (pr < 0) ? (cyc % 2 == 1) : ($urandom_range(99) < pr);
      reset = (prst > 0) && ($urandom_range(999) < prst);
      @(negedge clk);
      f0 = in0_valid && in0_ready;
      f1 = in1_valid && in1_ready;
      if (out_valid && out_ready)
        xlog.push_back('{cyc: cyc, ch: out_channel, data: out_data, eop: out_endofpacket});
      @(posedge clk);
      #1;
      if (f0) void'(q0.pop_front());
      if (f1) void'(q1.pop_front());
      cyc++;
    end
    reset = 0;
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); xlog.delete();
    in0_valid = 0; in1_valid = 0; out_ready = 0;
    reset = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 0;
    cyc = 0;
  endtask

  initial begin
    reset = 1; out_ready = 0;
    in0_valid = 0; in0_data = 0; in0_error = 0; in0_startofpacket = 0; in0_endofpacket = 0;
    in0_empty = 0;
    in1_valid = 0; in1_data = 0; in1_error = 0; in1_startofpacket = 0; in1_endofpacket = 0;
    in1_empty = 0;

    // Reset state
    do_reset();
    chk("lit_rst_pkt_cnt0", pkt_cnt0, 0);
    chk("lit_rst_drop_cnt", drop_cnt, 0);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_channel", out_channel, 1);

    // Tie after reset: sink 0 first, one bubble, then sink 1
    do_reset();
    add_pkt(0, 3, 32'h100);
    add_pkt(1, 3, 32'h200);
    run_cycles(10, 100, 100, 100, 0);
    chk("lit_tie_len", xlog.size(), 6);
    for (int i = 0; i < xlog.size() && i < 6; i++) begin
      chk("lit_tie_cyc", xlog[i].cyc, (i < 3) ? i + 1 : i + 2);
      chk("lit_tie_ch", xlog[i].ch, (i >= 3) ? 1 : 0);
      chk("lit_tie_data", xlog[i].data, (i < 3) ? 32'h100 + i : 32'h200 + i - 3);
    end
    chk("lit_tie_pkt0", pkt_cnt0, 1);
    chk("lit_tie_pkt1", pkt_cnt1, 1);

    // Backpressure: sink 1 keeps the grant while sink 0 waits with SOP
    do_reset();
    add_pkt(1, 4, 32'h300);
    run_cycles(1, 100, 100, 0, 0);
    add_pkt(0, 3, 32'h400);
    run_cycles(20, 100, 100, -1, 0);
    chk("lit_bp_len", xlog.size(), 7);
    for (int i = 0; i < xlog.size() && i < 4; i++) begin
      chk("lit_bp_ch", xlog[i].ch, 1);
      chk("lit_bp_data", xlog[i].data, 32'h300 + i);
    end
    if (xlog.size() > 4) begin
      chk("lit_bp_eop", xlog[3].eop, 1);
      chk("lit_bp_next_ch", xlog[4].ch, 0);
      chk("lit_bp_next_data", xlog[4].data, 32'h400);
    end

    // Stray beats in idle are drained and counted
    do_reset();
    add_beat(0, 32'h500, 0, 0);
    add_beat(0, 32'h501, 0, 0);
    run_cycles(4, 100, 0, 100, 0);
    chk("lit_stray_drop", drop_cnt, 2);
    chk("lit_stray_out", xlog.size(), 0);

    // Single-beat packets from sink 1, two cycles apart
    do_reset();
    for (int i = 0; i < 5; i++) add_pkt(1, 1, 32'h600 + i);
    run_cycles(12, 0, 100, 100, 0);
    chk("lit_single_len", xlog.size(), 5);
    for (int i = 0; i < xlog.size() && i < 5; i++) chk("lit_single_cyc", xlog[i].cyc, 1 + 2 * i);
    chk("lit_single_pkt1", pkt_cnt1, 5);

    // Reset mid-packet: tail beats become strays
    do_reset();
    add_pkt(0, 4, 32'h700);
    run_cycles(3, 100, 0, 100, 0);
    chk("lit_mid_pre_len", xlog.size(), 2);
    run_cycles(1, 100, 0, 100, 1000);
    chk("lit_mid_busy", busy, 0);
    xlog.delete();
    run_cycles(4, 100, 0, 100, 0);
    chk("lit_mid_drop", drop_cnt, 2);
    chk("lit_mid_out", xlog.size(), 0);
    chk("lit_mid_pkt0", pkt_cnt0, 0);

    // Saturation on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) add_pkt(0, 2, 32'h800 + 16 * i);
    run_cycles(20, 100, 0, 100, 0);
    chk("lit_sat_pkt0", s_pkt_cnt0, 3);
    chk("lit_sat_main_pkt0", pkt_cnt0, 5);

    // Randomized traffic with strays, mid-packet SOPs and occasional resets
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 250; p++) begin
        if ($urandom_range(9) == 0) begin
          add_beat(s, $urandom, 0, 1'($urandom));
        end else begin
          int len;
          len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++)
            add_beat(s, $urandom, (i == 0) || ($urandom_range(19) == 0), i == len - 1);
        end
      end
    end
    run_cycles(4000, 70, 70, 75, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/de2_70_ethernet_st_tx_arbiter.md
DE2_70_ETHERNET_ST_TX_ARBITER -- requirements
Module: de2_70_ethernet_st_tx_arbiter

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, data bus width; EMPTY_W, default 2, empty field width; CNT_W, default 16, statistics counter width.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have sink 0 ports: in0_valid in 1; in0_ready out 1; in0_data in DATA_W; in0_error in 1; in0_startofpacket in 1; in0_endofpacket in 1; in0_empty in EMPTY_W.
REQ-005 SHALL have sink 1 ports: in1_valid, in1_ready, in1_data, in1_error, in1_startofpacket, in1_endofpacket, in1_empty, with the same directions and widths as sink 0.
REQ-006 SHALL have source ports: out_valid out 1; out_ready in 1; out_data out DATA_W; out_error out 1; out_startofpacket out 1; out_endofpacket out 1; out_empty out EMPTY_W; out_channel out 1 (index of granted sink).
REQ-007 SHALL have status outputs: pkt_cnt0 out CNT_W; pkt_cnt1 out CNT_W; drop_cnt out CNT_W; busy out 1.

Function
REQ-008 SHALL use Avalon-ST ready latency 0 on all interfaces; a beat transfers on a cycle where valid and ready are both high.
REQ-009 SHALL implement state machine IDLE, GRANT0, GRANT1; register last_grant (1 bit).
REQ-010 IDLE: out_valid=0; in0_ready and in1_ready SHALL be 0, except as given in REQ-014.
REQ-011 IDLE with exactly one sink presenting valid&&startofpacket SHALL go to GRANTk (k = that sink) on the next clock.
REQ-012 IDLE with both sinks presenting valid&&startofpacket SHALL grant the sink != last_grant (round-robin).
REQ-013 GRANTk: out_valid/data/error/sop/eop/empty SHALL combinationally equal the ink_* inputs; ink_ready=out_ready; the other sink's ready=0; out_channel=k; busy=1.
REQ-014 IDLE stray beat: a sink with valid=1 and startofpacket=0 SHALL get ready=1 and be discarded. Each discarded beat SHALL increment drop_cnt. Both sinks stray in the same cycle SHALL add 2. A sink with SOP SHALL never be drained.
REQ-015 GRANTk: a transfer with endofpacket=1 SHALL return to IDLE next clock, set last_grant=k and increment pkt_cntk. This applies to a single-beat packet (sop=eop=1).
REQ-016 A startofpacket beat arriving mid-packet in GRANTk SHALL be forwarded unchanged (no protocol repair).
REQ-017 The grant SHALL NOT change before the granted packet's EOP transfer, regardless of out_ready stalls or invalid cycles of the granted sink.
REQ-018 Arbitration latency SHALL be exactly one idle cycle: first beat no earlier than 1 clock after SOP appears in IDLE; one bubble cycle between back-to-back packets.
REQ-019 All counters SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-020 out_error, out_empty and out_data SHALL pass through with no modification; out_data is don't-care when out_valid=0.
REQ-021 out_channel SHALL hold last_grant in IDLE.

Reset
REQ-022 On reset=1 at a clock edge, the block SHALL enter IDLE and set last_grant=1 (sink 0 wins the first tie), pkt_cnt0/pkt_cnt1/drop_cnt=0, busy=0.
REQ-023 While reset=1, out_valid, in0_ready and in1_ready SHALL be 0.
REQ-024 Reset mid-packet SHALL abandon the packet with no EOP emitted. Remaining beats of that packet arrive without SOP and SHALL be drained per REQ-014.

Verification
REQ-025 Tie: both sinks present 3-beat packets, out_ready=1, after reset. Required: sink 0 packet on cycles 1-3, bubble, sink 1 packet on cycles 5-7. out_channel=0 then 1; pkt_cnt0=pkt_cnt1=1.
REQ-026 Backpressure: out_ready toggles 1/0 during a 4-beat sink 1 packet while sink 0 holds a SOP. Required: sink 0 is not granted before sink 1's EOP transfer; all 4 beats delivered in order.
REQ-027 Stray: sink 0 presents 2 non-SOP beats in IDLE. Required: in0_ready=1 for both, out_valid=0, drop_cnt=2.
REQ-028 Single-beat packets: sink 1 sends 5 packets with sop=eop=1, sink 0 idle. Required: 5 outputs spaced 2 cycles apart, pkt_cnt1=5.
REQ-029 Reset mid-packet: reset asserted after beat 2 of a 4-beat sink 0 packet, then released. Required: the next cycle is IDLE; beats 3-4 are drained; drop_cnt=2; no output EOP.
REQ-030 Saturation: CNT_W=2, 5 sink 0 packets. Required: pkt_cnt0 stays at 3.
